// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : id_ex_stage                                                       |
// | Brief  : ID/EX pipeline register with valid/ready handshake, operand       |
// |          forwarding and stall-time writeback refresh (macro ID_EX_FWD_EN). |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module id_ex_stage #(
  parameter logic [3:0] RST_OP = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic [31:0] i_imm,
  input  logic [4:0]  i_rs_addr,
  input  logic [4:0]  i_rt_addr,
  input  logic [4:0]  i_rd_addr,
  input  logic [3:0]  i_alu_op,
  input  logic        i_alu_sel_imm,
  input  logic        i_reg_write,
  input  logic        i_exmem_we,
  input  logic [4:0]  i_exmem_rd,
  input  logic [31:0] i_exmem_result,
  input  logic        i_memwb_we,
  input  logic [4:0]  i_memwb_rd,
  input  logic [31:0] i_memwb_result,
  input  logic        i_flush,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_data_a,
  output logic [31:0] o_data_b,
  output logic [3:0]  o_operation,
  output logic [31:0] o_store_data,
  output logic [4:0]  o_out_rd,
  output logic        o_out_reg_write
);

  logic        r_valid;
  logic        r_reg_write;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_store;
  logic [4:0]  r_rd;

  logic        w_capture;
  logic        w_drain;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic        w_hit_rs;
  logic        w_hit_rt;

  assign o_in_ready = !r_valid || i_out_ready;
  assign w_capture  = i_in_valid && o_in_ready && !i_flush;
  assign w_drain    = r_valid && i_out_ready;

`ifdef ID_EX_FWD_EN
  logic [4:0] r_rs_addr;
  logic [4:0] r_rt_addr;
  logic       r_sel_imm;

  // Youngest producer wins: EX/MEM result is newer than MEM/WB.
  always_comb begin
    w_rs_val = i_rs_data;
    if (i_rs_addr == 5'd0)
      w_rs_val = 32'h0;
    else if (i_exmem_we && (i_exmem_rd == i_rs_addr))
      w_rs_val = i_exmem_result;
    else if (i_memwb_we && (i_memwb_rd == i_rs_addr))
      w_rs_val = i_memwb_result;
  end

  always_comb begin
    w_rt_val = i_rt_data;
    if (i_rt_addr == 5'd0)
      w_rt_val = 32'h0;
    else if (i_exmem_we && (i_exmem_rd == i_rt_addr))
      w_rt_val = i_exmem_result;
    else if (i_memwb_we && (i_memwb_rd == i_rt_addr))
      w_rt_val = i_memwb_result;
  end

  assign w_hit_rs = i_memwb_we && (i_memwb_rd != 5'd0) && (i_memwb_rd == r_rs_addr);
  assign w_hit_rt = i_memwb_we && (i_memwb_rd != 5'd0) && (i_memwb_rd == r_rt_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs_addr <= 5'd0;
      r_rt_addr <= 5'd0;
      r_sel_imm <= 1'b0;
    end else if (w_capture) begin
      r_rs_addr <= i_rs_addr;
      r_rt_addr <= i_rt_addr;
      r_sel_imm <= i_alu_sel_imm;
    end
  end
`else
  assign w_rs_val = (i_rs_addr == 5'd0) ? 32'h0 : i_rs_data;
  assign w_rt_val = (i_rt_addr == 5'd0) ? 32'h0 : i_rt_data;
  assign w_hit_rs = 1'b0;
  assign w_hit_rt = 1'b0;

  logic w_unused;
  assign w_unused = ^{i_exmem_we, i_exmem_rd, i_exmem_result,
                      i_memwb_we, i_memwb_rd, i_memwb_result};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_op        <= RST_OP;
      r_a         <= 32'h0;
      r_b         <= 32'h0;
      r_store     <= 32'h0;
      r_rd        <= 5'd0;
    end else if (i_flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_op        <= RST_OP;
    end else if (w_capture) begin
      r_valid     <= 1'b1;
      r_reg_write <= i_reg_write;
      r_op        <= i_alu_op;
      r_a         <= w_rs_val;
      r_b         <= i_alu_sel_imm ? i_imm : w_rt_val;
      r_store     <= w_rt_val;
      r_rd        <= i_rd_addr;
    end else if (w_drain) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_op        <= RST_OP;
    end else if (r_valid) begin
      // Stalled beat picks up a late writeback so it never carries stale data.
      if (w_hit_rs)
        r_a <= i_memwb_result;
      if (w_hit_rt) begin
        r_store <= i_memwb_result;
`ifdef ID_EX_FWD_EN
        if (!r_sel_imm)
          r_b <= i_memwb_result;
`endif
      end
    end
  end

  assign o_out_valid     = r_valid;
  assign o_out_reg_write = r_valid && r_reg_write;
  assign o_operation     = r_op;
  assign o_data_a        = r_a;
  assign o_data_b        = r_b;
  assign o_store_data    = r_store;
  assign o_out_rd        = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_id_ex_stage                                                    |
// | Brief  : self-checking bench for id_ex_stage (honours ID_EX_FWD_EN).       |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] rs_data, rt_data, imm;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [3:0]  alu_op;
  logic        alu_sel_imm, reg_write;
  logic        exmem_we;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_we;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] data_a, data_b, store_data;
  logic [3:0]  operation;
  logic [4:0]  out_rd;
  logic        out_reg_write;

  id_ex_stage #(.RST_OP(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_rs_data(rs_data), .i_rt_data(rt_data), .i_imm(imm),
    .i_rs_addr(rs_addr), .i_rt_addr(rt_addr), .i_rd_addr(rd_addr),
    .i_alu_op(alu_op), .i_alu_sel_imm(alu_sel_imm), .i_reg_write(reg_write),
    .i_exmem_we(exmem_we), .i_exmem_rd(exmem_rd), .i_exmem_result(exmem_result),
    .i_memwb_we(memwb_we), .i_memwb_rd(memwb_rd), .i_memwb_result(memwb_result),
    .i_flush(flush),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_data_a(data_a), .o_data_b(data_b), .o_operation(operation),
    .o_store_data(store_data), .o_out_rd(out_rd), .o_out_reg_write(out_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, im;
    logic [3:0]  op;
    logic        sel, rw;
    logic        exwe;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        wbwe;
    logic [4:0]  wbrd;
    logic [31:0] wbres;
    logic        fl;
    logic        ev, erw;
    logic [3:0]  eop;
    logic [31:0] ea, eb, es;
  } vec_t;

  typedef struct {
    logic [31:0] a, b, s;
    logic [3:0]  op;
    logic [4:0]  rd;
  } exp_t;

  localparam int NV = 8;
  vec_t tv [NV];
  exp_t sb [$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
    input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] im,
    input logic [3:0] op, input logic sel, input logic rw,
    input logic exwe, input logic [4:0] exrd, input logic [31:0] exres,
    input logic wbwe, input logic [4:0] wbrd, input logic [31:0] wbres,
    input logic fl, input logic ev, input logic erw, input logic [3:0] eop,
    input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] es);
    vec_t v;
    v.rs = rs; v.rt = rt; v.rd = rd; v.rsd = rsd; v.rtd = rtd; v.im = im;
    v.op = op; v.sel = sel; v.rw = rw;
    v.exwe = exwe; v.exrd = exrd; v.exres = exres;
    v.wbwe = wbwe; v.wbrd = wbrd; v.wbres = wbres;
    v.fl = fl; v.ev = ev; v.erw = erw; v.eop = eop;
    v.ea = ea; v.eb = eb; v.es = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    in_valid = 0; rs_data = 0; rt_data = 0; imm = 0;
    rs_addr = 0; rt_addr = 0; rd_addr = 0; alu_op = 0;
    alu_sel_imm = 0; reg_write = 0;
    exmem_we = 0; exmem_rd = 0; exmem_result = 0;
    memwb_we = 0; memwb_rd = 0; memwb_result = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic beat(input logic [4:0] rs, input logic [31:0] rsd,
                      input logic [4:0] rt, input logic [31:0] rtd,
                      input logic [31:0] im, input logic sel,
                      input logic [4:0] rd, input logic [3:0] op);
    in_valid = 1; rs_addr = rs; rs_data = rsd; rt_addr = rt; rt_data = rtd;
    imm = im; alu_sel_imm = sel; rd_addr = rd; alu_op = op; reg_write = 1;
  endtask

  task automatic apply(input vec_t v);
    in_valid = 1; out_ready = 1;
    rs_addr = v.rs; rt_addr = v.rt; rd_addr = v.rd;
    rs_data = v.rsd; rt_data = v.rtd; imm = v.im;
    alu_op = v.op; alu_sel_imm = v.sel; reg_write = v.rw;
    exmem_we = v.exwe; exmem_rd = v.exrd; exmem_result = v.exres;
    memwb_we = v.wbwe; memwb_rd = v.wbrd; memwb_result = v.wbres;
    flush = v.fl;
  endtask

  initial begin
    tv[0] = mk(3, 4, 9, 32'h10, 32'h20, 32'h0, 4'h2, 0, 1, 0, 0, 0, 0, 0, 0,
               0, 1, 1, 4'h2, 32'h10, 32'h20, 32'h20);
    tv[1] = mk(5, 6, 10, 32'h5555, 32'h66, 32'h0, 4'h3, 0, 1, 1, 5, 32'hAAAA, 1, 5, 32'hBBBB,
               0, 1, 1, 4'h3, FWD ? 32'hAAAA : 32'h5555, 32'h66, 32'h66);
    tv[2] = mk(1, 2, 11, 32'h11, 32'h22, 32'hFFFF_FFF0, 4'h4, 1, 0, 1, 9, 32'hDEAD, 1, 2, 32'hCCCC,
               0, 1, 0, 4'h4, 32'h11, 32'hFFFF_FFF0, FWD ? 32'hCCCC : 32'h22);
    tv[3] = mk(0, 0, 12, 32'h1234, 32'h55, 32'h0, 4'h6, 0, 1, 1, 0, 32'h999, 1, 0, 32'h888,
               0, 1, 1, 4'h6, 32'h0, 32'h0, 32'h0);
    tv[4] = mk(7, 8, 13, 32'h77, 32'h78, 32'h0, 4'h7, 0, 1, 0, 7, 32'hEEEE, 0, 8, 32'hFFFF,
               0, 1, 1, 4'h7, 32'h77, 32'h78, 32'h78);
    tv[5] = mk(3, 4, 14, 32'h1, 32'h2, 32'h0, 4'h9, 0, 1, 0, 0, 0, 0, 0, 0,
               1, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
    tv[6] = mk(9, 10, 15, 32'hA5A5_0000, 32'h5A5A, 32'h100, 4'hF, 1, 1, 0, 0, 0, 0, 0, 0,
               0, 1, 1, 4'hF, 32'hA5A5_0000, 32'h100, 32'h5A5A);
    tv[7] = mk(2, 3, 16, 32'h2, 32'h3, 32'h0, 4'h1, 0, 1, 1, 3, 32'h3333, 1, 3, 32'h4444,
               0, 1, 1, 4'h1, 32'h2, FWD ? 32'h3333 : 32'h3, FWD ? 32'h3333 : 32'h3);

    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_op", operation, 4'h0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rw", out_reg_write, 0);
    rst_n = 1;

    for (int i = 0; i < NV; i++) begin
      apply(tv[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), out_valid, tv[i].ev);
      chk($sformatf("v%0d_rw", i), out_reg_write, tv[i].erw);
      chk($sformatf("v%0d_op", i), operation, tv[i].eop);
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      if (tv[i].ev) begin
        chk($sformatf("v%0d_a", i), data_a, tv[i].ea);
        chk($sformatf("v%0d_b", i), data_b, tv[i].eb);
        chk($sformatf("v%0d_store", i), store_data, tv[i].es);
        chk($sformatf("v%0d_rd", i), out_rd, tv[i].rd);
      end
    end
    idle();
    @(posedge clk);
    #1;
    chk("drain_valid", out_valid, 0);
    chk("drain_op", operation, 4'h0);
    chk("drain_rw", out_reg_write, 0);

    // Stalled beat refreshed by a MEM/WB write to rt, with and without imm.
    for (int s = 0; s < 2; s++) begin
      idle();
      beat(8, 32'h80, 7, 32'h70, 32'hFEED_0000, s[0], 3, 4'h5);
      @(posedge clk);
      #1;
      chk("stall_cap_valid", out_valid, 1);
      rs_data = 32'hDEAD_BEEF; rt_data = 32'hDEAD_BEEF; alu_op = 4'hC;
      out_ready = 0;
      memwb_we = 1; memwb_rd = 7; memwb_result = 32'h1234;
      #1;
      chk("stall_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_op", operation, 4'h5);
      chk("stall_a", data_a, 32'h80);
      chk("stall_store", store_data, FWD ? 32'h1234 : 32'h70);
      chk("stall_b", data_b, s[0] ? 32'hFEED_0000 : (FWD ? 32'h1234 : 32'h70));
      idle();
      @(posedge clk);
      #1;
      chk("stall_release_valid", out_valid, 0);
    end

    // Back-to-back stream through the scoreboard.
    idle();
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      logic [31:0] ra, rb, ri;
      logic        sl;
      ra = $urandom; rb = $urandom; ri = $urandom; sl = k[0];
      beat(5'(k + 1), ra, 5'(k + 11), rb, ri, sl, 5'(k + 20), 4'(k + 8));
      e.a = ra; e.b = sl ? ri : rb; e.s = rb; e.op = 4'(k + 8); e.rd = 5'(k + 20);
      sb.push_back(e);
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d_valid", k), out_valid, 1);
      chk($sformatf("b2b%0d_in_ready", k), in_ready, 1);
      if (sb.size() == 0) begin
        chk("b2b_sb_underflow", 1, 0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk($sformatf("b2b%0d_a", k), data_a, x.a);
        chk($sformatf("b2b%0d_b", k), data_b, x.b);
        chk($sformatf("b2b%0d_store", k), store_data, x.s);
        chk($sformatf("b2b%0d_op", k), operation, x.op);
        chk($sformatf("b2b%0d_rd", k), out_rd, x.rd);
      end
    end
    idle();
    @(posedge clk);
    #1;
    chk("b2b_end_valid", out_valid, 0);
    chk("b2b_sb_empty", sb.size(), 0);

    // Asynchronous reset while a beat is held, then first capture after release.
    beat(4, 32'h44, 6, 32'h66, 32'h0, 0, 2, 4'h3);
    @(posedge clk);
    #1;
    idle();
    out_ready = 0;
    #2;
    rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_op", operation, 4'h0);
    chk("arst_a", data_a, 0);
    chk("arst_rd", out_rd, 0);
    chk("arst_in_ready", in_ready, 1);
    beat(1, 32'h99, 2, 32'h98, 32'h0, 0, 5, 4'hA);
    out_ready = 1;
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_a", data_a, 32'h99);
    chk("post_rst_op", operation, 4'hA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL declare parameter: RST_OP, 4'b0000, operation value driven while in reset or empty.
REQ-002 SHALL be one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1  decode beat present; in_ready  out  1  stage can accept.
REQ-006 rs_data, rt_data  in  32  register-file read data; imm  in  32  sign-extended immediate.
REQ-007 rs_addr, rt_addr, rd_addr  in  5  source/destination register numbers.
REQ-008 alu_op  in  4  ALU operation code; alu_sel_imm  in  1  1 selects imm as operand B; reg_write  in  1  instruction writes rd.
REQ-009 exmem_we  in  1, exmem_rd  in  5, exmem_result  in  32  EX/MEM forwarding source.
REQ-010 memwb_we  in  1, memwb_rd  in  5, memwb_result  in  32  MEM/WB forwarding source.
REQ-011 flush  in  1  discard held and incoming beat.
REQ-012 out_valid  out  1, out_ready  in  1  handshake to ALU/EX stage.
REQ-013 data_a, data_b  out  32  ALU operands; operation  out  4  ALU code; store_data  out  32  forwarded rt value.
REQ-014 out_rd  out  5, out_reg_write  out  1  destination info for later stages.

Function
REQ-015 Single-entry register; in_ready SHALL equal (!out_valid | out_ready).
REQ-016 Capture SHALL occur on the rising edge where in_valid & in_ready & !flush; outputs update one cycle after capture (latency 1).
REQ-017 out_valid SHALL clear at an edge with out_ready=1 and no capture; simultaneous drain and capture SHALL load the new beat with out_valid staying 1 (full throughput, no bubble).
REQ-018 While out_valid & !out_ready all outputs SHALL hold except per REQ-022.
REQ-019 flush SHALL have priority: next edge out_valid=0, out_reg_write=0, operation=RST_OP, incoming beat dropped; in_ready is still computed per REQ-015.
REQ-020 Operand resolution at capture, per source (rs, rt): address 0 -> 32'h0; else exmem_we & exmem_rd match -> exmem_result; else memwb_we & memwb_rd match -> memwb_result; else register-file data.
REQ-021 data_a = resolved rs; store_data = resolved rt; data_b = imm if alu_sel_imm else resolved rt.
REQ-022 While holding, a memwb_we write whose memwb_rd (nonzero) matches a held rs or rt address SHALL overwrite the corresponding held operand(s) next edge; data_b only updated if the held beat did not select imm.
REQ-023 Widths are exact 32-bit; no arithmetic performed; operation passes alu_op unchanged.
REQ-024 out_reg_write SHALL be 0 whenever out_valid=0.

Reset
REQ-025 rst_n low SHALL immediately force out_valid=0, out_reg_write=0, operation=RST_OP, data_a=data_b=store_data=0, out_rd=0; in_ready=1.
REQ-026 Reset mid-hold SHALL discard the held beat; first capture allowed on the first edge after rst_n rises.

Configuration
REQ-027 Macro ID_EX_FWD_EN defined: forwarding per REQ-020 and hold refresh per REQ-022.
REQ-028 ID_EX_FWD_EN undefined: operands taken raw from rs_data/rt_data (address 0 still forced to 0), no hold refresh; exmem_*/memwb_* ports remain present and are ignored.

Verification
REQ-029 Reset: rst_n=0 mid-beat -> out_valid=0, operation=4'b0000, data_a=0 same cycle.
REQ-030 Plain capture: rs=3 data 32'h10, rt=4 data 32'h20, alu_op=0010, no forwards -> next cycle data_a=32'h10, data_b=32'h20, operation=0010.
REQ-031 Forward priority: rs=5, exmem_rd=5 result 32'hAAAA, memwb_rd=5 result 32'hBBBB -> data_a=32'hAAAA; with ID_EX_FWD_EN undefined -> raw rs_data.
REQ-032 Stall refresh: held rt=7, alu_sel_imm=0, out_ready=0, memwb_we=1 rd=7 result 32'h1234 -> data_b=store_data=32'h1234 next cycle, out_valid stays 1.
REQ-033 Back-to-back: in_valid=1, out_ready=1 for 4 cycles -> 4 beats out in order, out_valid continuously 1, in_ready=1 throughout.
REQ-034 Flush with capture: in_valid=1, flush=1 -> next cycle out_valid=0, out_reg_write=0; rs=0 with exmem_rd=0 forward -> data_a=0.
